// File: rtl/tinyml_source_common_tdpram_port_arbiter_pkg.sv
// Shared types and helpers for the TDP RAM port arbiter: read-latency encodings,
// requester ID type, response pipeline tag, lock state and one-hot/ID conversions.
package tinyml_source_common_tdpram_port_arbiter_pkg;

  localparam int RD_LAT_NO_OUTREG = 1;
  localparam int RD_LAT_OUTREG    = 2;

  // IDs are sized for the largest supported requester count so every instance shares one tag layout
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_tag_t;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_state_t;

  function automatic req_id_t ohToId(input logic [MAX_REQ-1:0] oh);
    req_id_t id;
    id = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) id = id | req_id_t'(i);
    end
    return id;
  endfunction

  function automatic logic [MAX_REQ-1:0] idToOh(input req_id_t id);
    logic [MAX_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tinyml_source_common_tdpram_port_arbiter_if.sv
// Requester-side bus of the TDP RAM port arbiter: packed per-client requests,
// one-hot grants and tagged read responses.
interface tinyml_source_common_tdpram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_dout;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_din,
    input  req_ready, rsp_valid, rsp_dout
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_din,
    output req_ready, rsp_valid, rsp_dout
  );
endinterface

// File: rtl/tinyml_source_common_rr_picker.sv
// Rotating-priority picker: grants the first set request found scanning upward
// from the pointer, wrapping from NUM_REQ-1 back to 0.
module tinyml_source_common_rr_picker
  import tinyml_source_common_tdpram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  req_id_t            ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output req_id_t            grant_id_o,
  output logic               any_o
);

  logic       found;
  logic [3:0] slot;

  // ptr_i and the offset are both below NUM_REQ, so a single subtraction wraps the slot
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    slot    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = {1'b0, ptr_i} + 4'(i);
      if (slot >= 4'(NUM_REQ)) slot = slot - 4'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (slot == 4'(j)) && req_i[j]) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  assign grant_id_o = ohToId(MAX_REQ'(grant_o));
  assign any_o      = |req_i;

endmodule

// File: rtl/tinyml_source_common_tdpram_port_arbiter.sv
// Round-robin arbiter sharing one TDP RAM port between NUM_REQ clients, with tagged read responses.
// Optional burst lock enabled by defining TINYML_TDPRAM_ARB_BURST_LOCK_EN.
module tinyml_source_common_tdpram_port_arbiter
  import tinyml_source_common_tdpram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = RD_LAT_NO_OUTREG,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  tinyml_source_common_tdpram_port_arbiter_if.slave bus,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic [NUM_REQ-1:0]    grant;
  req_id_t               grantId;
  req_id_t               nextId;
  logic                  anyReq;
  logic                  accept;
  logic                  winWe;
  logic [ADDR_WIDTH-1:0] winAddr;
  logic [DATA_WIDTH-1:0] winDin;
  req_id_t               ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addrHold_q;
  logic [DATA_WIDTH-1:0] dinHold_q;
  rsp_tag_t              pipe_q [RD_LATENCY];
  rsp_tag_t              newTag;
  rsp_tag_t              outTag;
  logic [MAX_REQ-1:0]    rspOh;

  tinyml_source_common_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i      (bus.req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .grant_id_o (grantId),
    .any_o      (anyReq)
  );

  assign accept = anyReq & ~rst;
  assign winWe  = |(grant & bus.req_we);
  assign nextId = (grantId == req_id_t'(NUM_REQ - 1)) ? '0 : grantId + req_id_t'(1);

  always_comb begin
    winAddr = '0;
    winDin  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        winAddr = bus.req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        winDin  = bus.req_din[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef TINYML_TDPRAM_ARB_BURST_LOCK_EN
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);

  lock_state_t       lockState_q, lockState_d;
  req_id_t           lockId_q, lockId_d;
  logic [LOCK_W-1:0] lockCnt_q, lockCnt_d;
  logic [LOCK_W-1:0] beats;
  logic              winLock;

  assign winLock = |(grant & bus.req_lock);

  // A locked winner keeps the pointer on itself until it has taken MAX_LOCK consecutive beats
  always_comb begin
    ptr_d       = ptr_q;
    lockState_d = LOCK_IDLE;
    lockId_d    = lockId_q;
    lockCnt_d   = '0;
    beats       = '0;
    if (accept) begin
      ptr_d = nextId;
      if (winLock) begin
        beats = ((lockState_q == LOCK_HELD) && (lockId_q == grantId)) ?
                lockCnt_q + LOCK_W'(1) : LOCK_W'(1);
        if (beats < LOCK_W'(MAX_LOCK)) begin
          ptr_d       = grantId;
          lockState_d = LOCK_HELD;
          lockId_d    = grantId;
          lockCnt_d   = beats;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lockState_q <= LOCK_IDLE;
      lockId_q    <= '0;
      lockCnt_q   <= '0;
    end else begin
      lockState_q <= lockState_d;
      lockId_q    <= lockId_d;
      lockCnt_q   <= lockCnt_d;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^{bus.req_lock, MAX_LOCK[0]};

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = nextId;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      addrHold_q <= '0;
      dinHold_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      addrHold_q <= ram_addr;
      dinHold_q  <= ram_din;
    end
  end

  // Read tags travel alongside the RAM read so responses line up with ram_dout
  assign newTag = '{valid: accept & ~winWe, id: grantId};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= newTag;
      for (int k = 1; k < RD_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign outTag = pipe_q[RD_LATENCY-1];
  assign rspOh  = idToOh(outTag.id);

  always_comb begin
    bus.req_ready = rst ? '0 : grant;
    bus.rsp_valid = (outTag.valid && !rst) ? rspOh[NUM_REQ-1:0] : '0;
    bus.rsp_dout  = ram_dout;
    ram_we        = accept & winWe;
    ram_addr      = accept ? winAddr : addrHold_q;
    ram_din       = accept ? winDin  : dinHold_q;
  end

endmodule

// File: tb/tb_tinyml_source_common_tdpram_port_arbiter.sv
// Directed bench: two arbiter instances (RD_LATENCY 1 and 2) share one stimulus,
// each backed by a behavioural RAM port of matching latency.
module tb_tinyml_source_common_tdpram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqValid, reqWe, reqLock;
  logic [35:0] reqAddr;
  logic [31:0] reqDin;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  expMem [16];
  logic [3:0]  lockSeq [7];

  logic       ramWeA, ramWeB;
  logic [8:0] ramAddrA, ramAddrB;
  logic [7:0] ramDinA, ramDinB, ramDoutA, ramDoutB;
  logic [7:0] memA [512];
  logic [7:0] memB [512];
  logic [7:0] doutB1;

  always #5 clk = ~clk;

  tinyml_source_common_tdpram_port_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(9)) ifA ();
  tinyml_source_common_tdpram_port_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(9)) ifB ();

  assign ifA.req_valid = reqValid;
  assign ifA.req_we    = reqWe;
  assign ifA.req_lock  = reqLock;
  assign ifA.req_addr  = reqAddr;
  assign ifA.req_din   = reqDin;
  assign ifB.req_valid = reqValid;
  assign ifB.req_we    = reqWe;
  assign ifB.req_lock  = reqLock;
  assign ifB.req_addr  = reqAddr;
  assign ifB.req_din   = reqDin;

  tinyml_source_common_tdpram_port_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(9), .RD_LATENCY(1), .MAX_LOCK(4)
  ) dutA (
    .clk(clk), .rst(rst), .bus(ifA),
    .ram_we(ramWeA), .ram_addr(ramAddrA), .ram_din(ramDinA), .ram_dout(ramDoutA)
  );

  tinyml_source_common_tdpram_port_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(9), .RD_LATENCY(2), .MAX_LOCK(4)
  ) dutB (
    .clk(clk), .rst(rst), .bus(ifB),
    .ram_we(ramWeB), .ram_addr(ramAddrB), .ram_din(ramDinB), .ram_dout(ramDoutB)
  );

  // Read-first RAM ports; B adds the output register
  always @(posedge clk) begin
    if (ramWeA) memA[ramAddrA] <= ramDinA;
    ramDoutA <= memA[ramAddrA];
    if (ramWeB) memB[ramAddrB] <= ramDinB;
    doutB1   <= memB[ramAddrB];
    ramDoutB <= doutB1;
  end

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk,
                               input logic [8:0] a0, input logic [8:0] a1,
                               input logic [8:0] a2, input logic [8:0] a3,
                               input logic [7:0] d);
    reqValid = v;
    reqWe    = we;
    reqLock  = lk;
    reqAddr  = {a3, a2, a1, a0};
    reqDin   = {d, d, d, d};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRsp(input string tag, input int lagA, input int lagB, input int lo, input int hi,
                          input logic [3:0] ohA, input logic [3:0] ohB,
                          input logic [7:0] datA, input logic [7:0] datB);
    logic inA, inB;
    inA = (lagA >= lo) && (lagA <= hi);
    inB = (lagB >= lo) && (lagB <= hi);
    checkOutput({tag, "RspA"}, 32'(ifA.rsp_valid), inA ? 32'(ohA) : 32'd0);
    checkOutput({tag, "RspB"}, 32'(ifB.rsp_valid), inB ? 32'(ohB) : 32'd0);
    if (inA) checkOutput({tag, "DoutA"}, 32'(ifA.rsp_dout), 32'(datA));
    if (inB) checkOutput({tag, "DoutB"}, 32'(ifB.rsp_dout), 32'(datB));
  endtask

  initial begin
`ifdef TINYML_TDPRAM_ARB_BURST_LOCK_EN
    lockSeq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
`else
    lockSeq = '{4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
`endif
    rst = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("rstReadyA", 32'(ifA.req_ready), 32'd0);
    checkOutput("rstReadyB", 32'(ifB.req_ready), 32'd0);
    checkOutput("rstRspA", 32'(ifA.rsp_valid), 32'd0);
    checkOutput("rstRspB", 32'(ifB.rsp_valid), 32'd0);
    checkOutput("rstWeA", 32'(ramWeA), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Preload addresses 0..9 through requester 3 writes
    for (int a = 0; a < 10; a++) begin
      expMem[a] = 8'(a * 7 + 3);
      applyStimulus(4'b1000, 4'b1000, 4'b0000, 9'd0, 9'd0, 9'd0, 9'(a), expMem[a]);
      @(negedge clk);
      checkOutput("wrReady", 32'(ifA.req_ready), 32'h8);
      checkOutput("wrWe", 32'(ramWeB), 32'd1);
      checkOutput("wrAddr", 32'(ramAddrA), 32'(a));
      checkOutput("wrDin", 32'(ramDinB), 32'(expMem[a]));
      checkRsp("wr", 0, 0, 1, 0, 4'b0000, 4'b0000, 8'd0, 8'd0);
      tick();
    end

    // All four read every cycle: rotation 0,1,2,3 and responses in the same order
    for (int c = 0; c < 10; c++) begin
      if (c < 8) applyStimulus(4'b1111, 4'b0000, 4'b0000, 9'd0, 9'd1, 9'd2, 9'd3, 8'd0);
      else       applyStimulus(4'b0000, 4'b0000, 4'b0000, 9'd0, 9'd1, 9'd2, 9'd3, 8'd0);
      @(negedge clk);
      checkOutput("rrReadyA", 32'(ifA.req_ready), (c < 8) ? 32'(1 << (c % 4)) : 32'd0);
      checkOutput("rrReadyB", 32'(ifB.req_ready), (c < 8) ? 32'(1 << (c % 4)) : 32'd0);
      checkRsp("rr", c - 1, c - 2, 0, 7,
               4'(1 << ((c + 3) % 4)), 4'(1 << ((c + 2) % 4)),
               expMem[(c + 3) % 4], expMem[(c + 2) % 4]);
      tick();
    end

    // Write 0xA5 to addr 5 from req0, then read it back from req2
    expMem[5] = 8'hA5;
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 9'd5, 9'd0, 9'd0, 9'd0, 8'hA5);
    @(negedge clk);
    checkOutput("wrbReady", 32'(ifA.req_ready), 32'h1);
    checkOutput("wrbWe", 32'(ramWeA), 32'd1);
    tick();
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 9'd0, 9'd0, 9'd5, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("wrbRdReady", 32'(ifB.req_ready), 32'h4);
    checkOutput("wrbRdWe", 32'(ramWeB), 32'd0);
    checkRsp("wrbW", 0, 0, 1, 0, 4'b0000, 4'b0000, 8'd0, 8'd0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 9'd0, 9'd0, 9'd5, 9'd0, 8'd0);
    for (int c = 2; c < 4; c++) begin
      @(negedge clk);
      checkRsp("wrb", c - 1, c - 2, 1, 1, 4'b0100, 4'b0100, 8'hA5, 8'hA5);
      tick();
    end

    // Single requester streaming 10 reads: ready every cycle, responses without bubbles
    for (int c = 0; c < 12; c++) begin
      if (c < 10) applyStimulus(4'b1000, 4'b0000, 4'b0000, 9'd0, 9'd0, 9'd0, 9'(c), 8'd0);
      else        applyStimulus(4'b0000, 4'b0000, 4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'd0);
      @(negedge clk);
      checkOutput("strReady", 32'(ifA.req_ready), (c < 10) ? 32'h8 : 32'd0);
      checkOutput("strAddr", 32'(ramAddrB), (c < 10) ? 32'(c) : 32'd9);
      checkRsp("str", c - 1, c - 2, 0, 9, 4'b1000, 4'b1000,
               expMem[(c + 15) % 16], expMem[(c + 14) % 16]);
      tick();
    end

    // Reset with reads in flight from req1
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 9'd0, 9'd2, 9'd0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("flyReady0", 32'(ifA.req_ready), 32'h2);
    tick();
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 9'd0, 9'd3, 9'd0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("flyReady1", 32'(ifA.req_ready), 32'h2);
    tick();
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'd0);
    @(negedge clk);
    checkRsp("flyRst", 0, 0, 1, 0, 4'b0000, 4'b0000, 8'd0, 8'd0);
    tick();
    rst = 1'b0;
    applyStimulus(4'b1110, 4'b0000, 4'b0000, 9'd0, 9'd4, 9'd4, 9'd4, 8'd0);
    @(negedge clk);
    checkRsp("flyPost", 0, 0, 1, 0, 4'b0000, 4'b0000, 8'd0, 8'd0);
    checkOutput("flyScanA", 32'(ifA.req_ready), 32'h2);
    checkOutput("flyScanB", 32'(ifB.req_ready), 32'h2);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 9'd0, 9'd4, 9'd4, 9'd4, 8'd0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      checkRsp("flyNew", c, c - 1, 1, 1, 4'b0010, 4'b0010, expMem[4], expMem[4]);
      tick();
    end

    // Park the pointer on req1, then req1 requests with lock while req0/req2 compete
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'd0);
    @(negedge clk);
    checkOutput("lkPark", 32'(ifA.req_ready), 32'h1);
    tick();
    for (int c = 0; c < 7; c++) begin
      applyStimulus(4'b0111, 4'b0000, 4'b0010, 9'd0, 9'd1, 9'd2, 9'd0, 8'd0);
      @(negedge clk);
      checkOutput($sformatf("lkGrantA%0d", c), 32'(ifA.req_ready), 32'(lockSeq[c]));
      checkOutput($sformatf("lkGrantB%0d", c), 32'(ifB.req_ready), 32'(lockSeq[c]));
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 9'd0, 9'd0, 9'd0, 9'd0, 8'd0);
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
